// File: rtl/i2c_reg_arbiter_pkg.sv
// Shared definitions for the I2C/local register arbiter: FSM encodings,
// grant identifiers and the value returned for out-of-range reads.
package i2c_reg_arbiter_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SERVE_A = 2'd1,
    SERVE_B = 2'd2
  } state_t;

  localparam logic [7:0] OOR_RDATA = 8'hFF;

  localparam logic GRANT_A = 1'b0;
  localparam logic GRANT_B = 1'b1;

  function automatic logic idx_in_range(input logic [7:0] idx, input int unsigned n);
    return 32'(idx) < n;
  endfunction

endpackage

// File: rtl/i2c_sync_bit.sv
// STAGES-deep flop chain bringing a single asynchronous level into the clk domain.
module i2c_sync_bit #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] ff;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) ff <= '0;
    else        ff <= {ff[STAGES-2:0], d};
  end

  assign q = ff[STAGES-1];

endmodule

// File: rtl/i2c_reg_arbiter.sv
// Register bank shared by an asynchronous 4-phase I2C port (A) and a local
// valid/ready port (B). Define I2C_ARB_FIXED_PRIO_EN to give A every tie.
module i2c_reg_arbiter
  import i2c_reg_arbiter_pkg::*;
#(
  parameter int         NUM_REGS    = 4,
  parameter int         SYNC_STAGES = 2,
  parameter logic [7:0] RST_VAL     = 8'h00
) (
  input  logic                  clk,
  input  logic                  RST_N,
  input  logic                  a_req,
  input  logic                  a_we,
  input  logic [7:0]            a_addr,
  input  logic [7:0]            a_wdata,
  output logic                  a_ack,
  output logic [7:0]            a_rdata,
  output logic                  a_err,
  input  logic                  b_valid,
  input  logic                  b_we,
  input  logic [7:0]            b_addr,
  input  logic [7:0]            b_wdata,
  output logic                  b_ready,
  output logic [7:0]            b_rdata,
  output logic                  b_err,
  output logic [8*NUM_REGS-1:0] regs_flat,
  output state_t                dbg_state
);

  localparam int AW = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;

  // Handshakes: port A is 4-phase (a_req high -> a_ack high -> a_req low ->
  // a_ack low), inputs held while a_req is high. Port B holds b_valid and its
  // inputs until b_ready pulses; b_valid in the b_ready cycle is not a new request.
  state_t         state, state_nxt;
  logic           a_req_s, a_busy, pend_a, pend_b;
  logic [7:0]     regs [NUM_REGS];
  logic           acc_en, acc_we, acc_ok;
  logic [7:0]     acc_addr, acc_wdata, acc_rd, acc_rval;
  logic [AW-1:0]  acc_idx;
`ifndef I2C_ARB_FIXED_PRIO_EN
  logic           last_grant;
`endif

  i2c_sync_bit #(.STAGES(SYNC_STAGES)) u_sync_a_req (
    .clk   (clk),
    .rst_n (RST_N),
    .d     (a_req),
    .q     (a_req_s)
  );

  assign pend_a    = a_req_s & ~a_busy;
  assign pend_b    = b_valid & ~b_ready;
  assign dbg_state = state;

  always_ff @(posedge clk or negedge RST_N) begin
    if (!RST_N) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE: begin
        if (pend_a && pend_b) begin
`ifdef I2C_ARB_FIXED_PRIO_EN
          state_nxt = SERVE_A;
`else
          state_nxt = (last_grant == GRANT_A) ? SERVE_B : SERVE_A;
`endif
        end else if (pend_a) begin
          state_nxt = SERVE_A;
        end else if (pend_b) begin
          state_nxt = SERVE_B;
        end
      end
      SERVE_A, SERVE_B: state_nxt = IDLE;
      default:          state_nxt = IDLE;
    endcase
  end

  // One access path, steered by whichever port holds the grant.
  always_comb begin
    acc_en    = (state == SERVE_A) || (state == SERVE_B);
    acc_we    = (state == SERVE_A) ? a_we    : b_we;
    acc_addr  = (state == SERVE_A) ? a_addr  : b_addr;
    acc_wdata = (state == SERVE_A) ? a_wdata : b_wdata;
  end

  assign acc_idx  = acc_addr[AW-1:0];
  assign acc_ok   = idx_in_range(acc_addr, NUM_REGS);
  assign acc_rd   = acc_ok ? regs[acc_idx] : OOR_RDATA;
  assign acc_rval = acc_we ? 8'h00 : acc_rd;

  always_ff @(posedge clk or negedge RST_N) begin
    if (!RST_N) begin
      for (int i = 0; i < NUM_REGS; i++) regs[i] <= RST_VAL;
    end else if (acc_en && acc_we && acc_ok) begin
      regs[acc_idx] <= acc_wdata;
    end
  end

  // Port A completion; release follows a_req_s independently of the FSM.
  always_ff @(posedge clk or negedge RST_N) begin
    if (!RST_N) begin
      a_ack   <= 1'b0;
      a_busy  <= 1'b0;
      a_err   <= 1'b0;
      a_rdata <= 8'h00;
    end else if (state == SERVE_A) begin
      a_ack   <= 1'b1;
      a_busy  <= 1'b1;
      a_err   <= ~acc_ok;
      a_rdata <= acc_rval;
    end else if (a_busy && !a_req_s) begin
      a_ack   <= 1'b0;
      a_busy  <= 1'b0;
      a_err   <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge RST_N) begin
    if (!RST_N) begin
      b_ready <= 1'b0;
      b_err   <= 1'b0;
      b_rdata <= 8'h00;
    end else begin
      b_ready <= (state == SERVE_B);
      if (state == SERVE_B) begin
        b_err   <= ~acc_ok;
        b_rdata <= acc_rval;
      end
    end
  end

`ifndef I2C_ARB_FIXED_PRIO_EN
  always_ff @(posedge clk or negedge RST_N) begin
    if (!RST_N)                 last_grant <= GRANT_B;
    else if (state == SERVE_A)  last_grant <= GRANT_A;
    else if (state == SERVE_B)  last_grant <= GRANT_B;
  end
`endif

  for (genvar g = 0; g < NUM_REGS; g++) begin : g_flat
    assign regs_flat[8*g +: 8] = regs[g];
  end

endmodule

// File: tb/tb_i2c_reg_arbiter.sv
// Directed bench for i2c_reg_arbiter: driver tasks issue accesses and push the
// expected responses; a negedge monitor pops and compares on each completion.
module tb_i2c_reg_arbiter;
  import i2c_reg_arbiter_pkg::*;

  localparam int         NUM_REGS = 4;
  localparam logic [7:0] RST_VAL  = 8'h00;

  logic                  clk, RST_N;
  logic                  a_req, a_we, b_valid, b_we;
  logic [7:0]            a_addr, a_wdata, b_addr, b_wdata;
  logic                  a_ack, a_err, b_ready, b_err;
  logic [7:0]            a_rdata, b_rdata;
  logic [8*NUM_REGS-1:0] regs_flat;
  state_t                dbg_state;

  i2c_reg_arbiter #(.NUM_REGS(NUM_REGS), .SYNC_STAGES(2), .RST_VAL(RST_VAL)) dut (
    .clk       (clk),
    .RST_N     (RST_N),
    .a_req     (a_req),
    .a_we      (a_we),
    .a_addr    (a_addr),
    .a_wdata   (a_wdata),
    .a_ack     (a_ack),
    .a_rdata   (a_rdata),
    .a_err     (a_err),
    .b_valid   (b_valid),
    .b_we      (b_we),
    .b_addr    (b_addr),
    .b_wdata   (b_wdata),
    .b_ready   (b_ready),
    .b_rdata   (b_rdata),
    .b_err     (b_err),
    .regs_flat (regs_flat),
    .dbg_state (dbg_state)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- scoreboard state ----------------
  logic [8:0] exp_a_q[$];
  logic [8:0] exp_b_q[$];
  logic       exp_g_q[$];
  logic       track_order;
  logic [7:0] exp_regs [NUM_REGS];
  logic [7:0] a_exp_rdata;
  int         n_vec, n_err;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic timeout(input string name);
    n_vec++;
    n_err++;
    $display("FAIL %s: no response within cycle budget at %0t", name, $time);
  endtask

  function automatic logic [31:0] model_flat();
    logic [31:0] r;
    r = '0;
    for (int i = 0; i < NUM_REGS; i++) r[8*i +: 8] = exp_regs[i];
    return r;
  endfunction

  // Expected {err, rdata} for an access, and model update for in-range writes.
  function automatic logic [8:0] model_access(input logic we, input logic [7:0] addr,
                                              input logic [7:0] wdata);
    logic       ok;
    logic [7:0] rd;
    ok = (int'(addr) < NUM_REGS);
    rd = 8'h00;
    if (!we) rd = ok ? exp_regs[addr[1:0]] : 8'hFF;
    if (we && ok) exp_regs[addr[1:0]] = wdata;
    return {~ok, rd};
  endfunction

  task automatic order_check(input logic port);
    if (track_order) begin
      if (exp_g_q.size() == 0) check("grant_extra", 32'(exp_g_q.size()), 32'd1);
      else                     check("grant_order", 32'(port), 32'(exp_g_q.pop_front()));
    end
  endtask

  // ---------------- monitor ----------------
  logic       a_ack_d;
  logic [8:0] e;
  always @(negedge clk) begin
    if (!RST_N) begin
      a_ack_d = 1'b0;
    end else begin
      if (b_ready) begin
        if (exp_b_q.size() == 0) check("b_unexpected_ready", 32'(exp_b_q.size()), 32'd1);
        else begin
          e = exp_b_q.pop_front();
          check("b_rdata", 32'(b_rdata), 32'(e[7:0]));
          check("b_err",   32'(b_err),   32'(e[8]));
          order_check(1'b1);
        end
      end
      if (a_ack && !a_ack_d) begin
        if (exp_a_q.size() == 0) check("a_unexpected_ack", 32'(exp_a_q.size()), 32'd1);
        else begin
          e = exp_a_q.pop_front();
          check("a_rdata", 32'(a_rdata), 32'(e[7:0]));
          check("a_err",   32'(a_err),   32'(e[8]));
          order_check(1'b0);
        end
      end
      a_ack_d = a_ack;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic do_reset();
    RST_N = 1'b0;
    a_req = 1'b0; a_we = 1'b0; a_addr = 8'h00; a_wdata = 8'h00;
    b_valid = 1'b0; b_we = 1'b0; b_addr = 8'h00; b_wdata = 8'h00;
    track_order = 1'b0;
    for (int i = 0; i < NUM_REGS; i++) exp_regs[i] = RST_VAL;
    repeat (3) @(negedge clk);
    RST_N = 1'b1;
  endtask

  task automatic b_access(input logic we, input logic [7:0] addr, input logic [7:0] wdata);
    int cyc;
    exp_b_q.push_back(model_access(we, addr, wdata));
    b_we = we; b_addr = addr; b_wdata = wdata; b_valid = 1'b1;
    cyc = 0;
    while (1) begin
      @(negedge clk);
      cyc++;
      if (b_ready) break;
      if (cyc >= 20) begin timeout("b_ready_wait"); break; end
    end
    check("b_latency", 32'(cyc), 32'd2);
    b_valid = 1'b0;
    @(negedge clk);
  endtask

  task automatic a_wait_ack();
    int cyc;
    cyc = 0;
    while (1) begin
      @(negedge clk);
      cyc++;
      if (a_ack) break;
      if (cyc >= 20) begin timeout("a_ack_wait"); break; end
    end
    check("a_ack_latency", 32'(cyc), 32'd4);
  endtask

  task automatic a_start(input logic we, input logic [7:0] addr, input logic [7:0] wdata);
    logic [8:0] r;
    r = model_access(we, addr, wdata);
    a_exp_rdata = r[7:0];
    exp_a_q.push_back(r);
    a_we = we; a_addr = addr; a_wdata = wdata; a_req = 1'b1;
    a_wait_ack();
  endtask

  task automatic a_release();
    int cyc;
    a_req = 1'b0;
    cyc = 0;
    while (1) begin
      @(negedge clk);
      cyc++;
      if (!a_ack) break;
      if (cyc >= 20) begin timeout("a_release_wait"); break; end
    end
    check("a_release_in_2_to_3", 32'(cyc >= 2 && cyc <= 3), 32'd1);
    check("a_err_cleared", 32'(a_err), 32'd0);
    check("a_rdata_held", 32'(a_rdata), 32'(a_exp_rdata));
  endtask

  // A request and B request become visible to the arbiter in the same cycle.
  task automatic tie(input logic aw, input logic [7:0] aa, input logic [7:0] ad,
                     input logic bw, input logic [7:0] ba, input logic [7:0] bd,
                     input logic a_first);
    int cyc;
    track_order = 1'b1;
    exp_g_q.push_back(a_first ? 1'b0 : 1'b1);
    exp_g_q.push_back(a_first ? 1'b1 : 1'b0);
    exp_a_q.push_back(model_access(aw, aa, ad));
    exp_b_q.push_back(model_access(bw, ba, bd));
    a_we = aw; a_addr = aa; a_wdata = ad; a_req = 1'b1;
    repeat (2) @(negedge clk);
    b_we = bw; b_addr = ba; b_wdata = bd; b_valid = 1'b1;
    cyc = 0;
    while (1) begin
      @(negedge clk);
      cyc++;
      if (b_valid && b_ready) b_valid = 1'b0;
      if (a_req && a_ack)     a_req = 1'b0;
      if (!b_valid && !a_req && !a_ack) break;
      if (cyc >= 40) begin timeout("tie_wait"); break; end
    end
    check("grant_all_seen", 32'(exp_g_q.size()), 32'd0);
    track_order = 1'b0;
    @(negedge clk);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    n_vec = 0; n_err = 0;
    RST_N = 1'b0;
    do_reset();

    check("rst_regs_flat", regs_flat, model_flat());
    check("rst_a_ack",   32'(a_ack),   32'd0);
    check("rst_b_ready", 32'(b_ready), 32'd0);
    check("rst_a_rdata", 32'(a_rdata), 32'd0);
    check("rst_b_rdata", 32'(b_rdata), 32'd0);
    check("rst_a_err",   32'(a_err),   32'd0);
    check("rst_b_err",   32'(b_err),   32'd0);
    check("rst_state",   32'(dbg_state), 32'(IDLE));

    // B write then read of the same register
    b_access(1'b1, 8'd1, 8'h57);
    b_access(1'b0, 8'd1, 8'h00);
    check("reg1_57", 32'(regs_flat[15:8]), 32'h57);

    // A write through the 4-phase handshake
    a_start(1'b1, 8'd3, 8'hA5);
    a_release();
    check("regs_after_a_write", regs_flat, model_flat());

    // Out-of-range accesses on both ports
    b_access(1'b0, 8'h07, 8'h00);
    a_start(1'b1, 8'h04, 8'h11);
    a_release();
    check("regs_after_oor_write", regs_flat, model_flat());

    // B proceeds while A waits for its release
    a_start(1'b0, 8'd3, 8'h00);
    b_access(1'b1, 8'd2, 8'h3C);
    check("a_ack_held_during_b", 32'(a_ack), 32'd1);
    a_release();
    check("reg2_3c", 32'(regs_flat[23:16]), 32'h3C);

    // Reset while A holds a_ack with a_req still high
    a_start(1'b1, 8'd0, 8'h99);
    #2 RST_N = 1'b0;
    for (int i = 0; i < NUM_REGS; i++) exp_regs[i] = RST_VAL;
    #1;
    check("midrst_a_ack", 32'(a_ack), 32'd0);
    check("midrst_regs", regs_flat, model_flat());
    @(negedge clk);
    RST_N = 1'b1;
    begin
      logic [8:0] r;
      r = model_access(1'b1, 8'd0, 8'h99);
      a_exp_rdata = r[7:0];
      exp_a_q.push_back(r);
    end
    a_wait_ack();
    a_release();
    check("regs_after_repeat", regs_flat, model_flat());

    // Arbitration: tie after reset goes to A, then a tie after an A grant
    do_reset();
    tie(1'b1, 8'd0, 8'h12, 1'b1, 8'd1, 8'h34, 1'b1);
    a_start(1'b0, 8'd0, 8'h00);
    a_release();
`ifdef I2C_ARB_FIXED_PRIO_EN
    tie(1'b1, 8'd2, 8'h56, 1'b0, 8'd1, 8'h00, 1'b1);
`else
    tie(1'b1, 8'd2, 8'h56, 1'b0, 8'd1, 8'h00, 1'b0);
`endif
    check("regs_after_ties", regs_flat, model_flat());

    repeat (3) @(negedge clk);
    check("a_queue_drained", 32'(exp_a_q.size()), 32'd0);
    check("b_queue_drained", 32'(exp_b_q.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
